// File: rtl/csr_rmw_unit.sv
// Zicsr read-modify-write unit: decodes CSR ops, resolves the old value through
// the output register and an in-flight write history, and registers rd/write-back.
module csr_rmw_unit #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [1:0]      priv,
  input  logic            flush,
  output logic [11:0]     csr_raddr,
  input  logic [XLEN-1:0] csr_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rd_data,
  output logic            out_wen,
  output logic [11:0]     out_waddr,
  output logic [XLEN-1:0] out_wdata,
  output logic            out_illegal
);

  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    F3_RW  = 3'b001,
    F3_RS  = 3'b010,
    F3_RC  = 3'b011,
    F3_RWI = 3'b101,
    F3_RSI = 3'b110,
    F3_RCI = 3'b111
  } csr_op_e;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rs1_field;
  logic            is_csr;
  logic            write_intent;
  logic            illegal;
  logic [XLEN-1:0] src;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] new_val;
  logic            unused_rd;

  logic [DEPTH-1:0] h_valid;
  logic [11:0]      h_addr [DEPTH];
  logic [XLEN-1:0]  h_data [DEPTH];

  assign opcode    = inst[6:0];
  assign funct3    = inst[14:12];
  assign rs1_field = inst[19:15];
  assign csr_raddr = inst[31:20];
  assign unused_rd = ^inst[11:7];

  assign in_ready = out_ready | ~out_valid;

  always_comb begin
    is_csr = 1'b0;
    case (funct3)
      F3_RW, F3_RS, F3_RC, F3_RWI, F3_RSI, F3_RCI: is_csr = (opcode == OPC_SYSTEM);
      default:                                     is_csr = 1'b0;
    endcase
  end

  // The I-forms reuse the rs1 field as a 5-bit zero-extended immediate.
  assign src = funct3[2] ? {{(XLEN-5){1'b0}}, rs1_field} : rs1_val;

  // Plain writes always write; set/clear forms write only with a nonzero rs1/zimm field.
  assign write_intent = (funct3[1:0] == 2'b01) | (rs1_field != 5'd0);

  assign illegal = (priv < csr_raddr[9:8]) |
                   (write_intent & (csr_raddr[11:10] == 2'b11));

  // Youngest writer wins: output register first, then h[0]..h[DEPTH-1], then the CSR file.
  always_comb begin
    old_val = csr_rdata;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (h_valid[i] && (h_addr[i] == csr_raddr)) begin
        old_val = h_data[i];
      end
    end
    if (out_valid && out_wen && (out_waddr == csr_raddr)) begin
      old_val = out_wdata;
    end
  end

  always_comb begin
    new_val = src;
    case (funct3[1:0])
      2'b10:   new_val = old_val | src;
      2'b11:   new_val = old_val & ~src;
      default: new_val = src;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_wen     <= 1'b0;
      out_illegal <= 1'b0;
      out_rd_data <= '0;
      out_waddr   <= '0;
      out_wdata   <= '0;
    end else if (flush) begin
      out_valid   <= 1'b0;
      out_wen     <= 1'b0;
      out_illegal <= 1'b0;
    end else if (in_ready) begin
      out_valid   <= in_valid & is_csr;
      out_wen     <= in_valid & is_csr & write_intent & ~illegal;
      out_illegal <= in_valid & is_csr & illegal;
      out_rd_data <= old_val;
      out_waddr   <= csr_raddr;
      out_wdata   <= new_val;
    end
  end

  // History mirrors writes still in flight to the CSR file; a flushed op enters as invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        h_addr[i] <= '0;
        h_data[i] <= '0;
      end
    end else if (out_ready) begin
      h_valid[0] <= out_valid & out_wen & ~flush;
      h_addr[0]  <= out_waddr;
      h_data[0]  <= out_wdata;
      for (int i = 1; i < DEPTH; i++) begin
        h_valid[i] <= h_valid[i-1];
        h_addr[i]  <= h_addr[i-1];
        h_data[i]  <= h_data[i-1];
      end
    end
  end

endmodule

// File: tb/tb_csr_rmw_unit.sv
// Directed self-checking bench for csr_rmw_unit; DEPTH=1 and DEPTH=4 copies
// share the stimulus to check how far the history bypass reaches.
module tb_csr_rmw_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] inst;
  logic [31:0] rs1_val;
  logic [1:0]  priv;
  logic        flush;
  logic [31:0] csr_rdata;
  logic        out_ready;

  logic        in_ready;
  logic [11:0] csr_raddr;
  logic        out_valid;
  logic [31:0] out_rd_data;
  logic        out_wen;
  logic [11:0] out_waddr;
  logic [31:0] out_wdata;
  logic        out_illegal;

  logic        d1_unused_ready, d1_unused_valid, d1_unused_wen, d1_unused_ill;
  logic [11:0] d1_unused_raddr, d1_unused_waddr;
  logic [31:0] d1_rd, d1_unused_wdata;
  logic        d4_unused_ready, d4_unused_valid, d4_unused_wen, d4_unused_ill;
  logic [11:0] d4_unused_raddr, d4_unused_waddr;
  logic [31:0] d4_rd, d4_unused_wdata;

  int total = 0;
  int bad   = 0;

  csr_rmw_unit #(.XLEN(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
    .rs1_val(rs1_val), .priv(priv), .flush(flush), .csr_raddr(csr_raddr),
    .csr_rdata(csr_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_rd_data(out_rd_data), .out_wen(out_wen), .out_waddr(out_waddr),
    .out_wdata(out_wdata), .out_illegal(out_illegal)
  );

  csr_rmw_unit #(.XLEN(32), .DEPTH(1)) dut_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d1_unused_ready), .inst(inst),
    .rs1_val(rs1_val), .priv(priv), .flush(flush), .csr_raddr(d1_unused_raddr),
    .csr_rdata(csr_rdata), .out_valid(d1_unused_valid), .out_ready(out_ready),
    .out_rd_data(d1_rd), .out_wen(d1_unused_wen), .out_waddr(d1_unused_waddr),
    .out_wdata(d1_unused_wdata), .out_illegal(d1_unused_ill)
  );

  csr_rmw_unit #(.XLEN(32), .DEPTH(4)) dut_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d4_unused_ready), .inst(inst),
    .rs1_val(rs1_val), .priv(priv), .flush(flush), .csr_raddr(d4_unused_raddr),
    .csr_rdata(csr_rdata), .out_valid(d4_unused_valid), .out_ready(out_ready),
    .out_rd_data(d4_rd), .out_wen(d4_unused_wen), .out_waddr(d4_unused_waddr),
    .out_wdata(d4_unused_wdata), .out_illegal(d4_unused_ill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] RW = 3'b001, RS = 3'b010, RC = 3'b011;
  localparam logic [2:0] RWI = 3'b101, RSI = 3'b110, RCI = 3'b111;

  function automatic logic [31:0] enc(input logic [2:0] f3, input logic [11:0] addr,
                                      input logic [4:0] rs1f);
    return {addr, rs1f, f3, 5'd1, 7'b1110011};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic [11:0] addr,
                       input logic [4:0] rs1f, input logic [31:0] rv);
    in_valid = 1'b1;
    inst     = enc(f3, addr, rs1f);
    rs1_val  = rv;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; priv = 2'd3;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (out_wen !== 1'b0) begin bad++; $display("[TB] FAIL reset_wen got=%b exp=0", out_wen); end
    total++; if (out_illegal !== 1'b0) begin bad++; $display("[TB] FAIL reset_illegal got=%b exp=0", out_illegal); end
    total++; if (out_rd_data !== 32'h0) begin bad++; $display("[TB] FAIL reset_rd got=%h exp=0", out_rd_data); end
    total++; if (out_waddr !== 12'h0) begin bad++; $display("[TB] FAIL reset_waddr got=%h exp=0", out_waddr); end
    total++; if (out_wdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_wdata got=%h exp=0", out_wdata); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready); end
    inst = enc(RW, 12'h340, 5'd1);
    #1;
    total++; if (csr_raddr !== 12'h340) begin bad++; $display("[TB] FAIL raddr got=%h exp=340", csr_raddr); end
  endtask

  task automatic test_basic();
    do_reset();
    csr_rdata = 32'h11111111;
    drive(RW, 12'h340, 5'd1, 32'hDEADBEEF);
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL basic_valid got=%b exp=1", out_valid); end
    total++; if (out_rd_data !== 32'h11111111) begin bad++; $display("[TB] FAIL basic_rd got=%h exp=11111111", out_rd_data); end
    total++; if (out_wen !== 1'b1) begin bad++; $display("[TB] FAIL basic_wen got=%b exp=1", out_wen); end
    total++; if (out_waddr !== 12'h340) begin bad++; $display("[TB] FAIL basic_waddr got=%h exp=340", out_waddr); end
    total++; if (out_wdata !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL basic_wdata got=%h exp=deadbeef", out_wdata); end
    total++; if (out_illegal !== 1'b0) begin bad++; $display("[TB] FAIL basic_illegal got=%b exp=0", out_illegal); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    csr_rdata = 32'h0;
    drive(RW, 12'h340, 5'd1, 32'h5);
    tick();
    drive(RSI, 12'h340, 5'd2, 32'hFFFF0000);
    tick();
    total++; if (out_rd_data !== 32'h5) begin bad++; $display("[TB] FAIL b2b_rd got=%h exp=5", out_rd_data); end
    total++; if (out_wdata !== 32'h7) begin bad++; $display("[TB] FAIL b2b_wdata got=%h exp=7", out_wdata); end
    total++; if (out_wen !== 1'b1) begin bad++; $display("[TB] FAIL b2b_wen got=%b exp=1", out_wen); end
    total++; if (d1_rd !== 32'h5) begin bad++; $display("[TB] FAIL b2b_d1_rd got=%h exp=5", d1_rd); end
    total++; if (d4_rd !== 32'h5) begin bad++; $display("[TB] FAIL b2b_d4_rd got=%h exp=5", d4_rd); end
    drive(RS, 12'h340, 5'd0, 32'h0);
    tick();
    in_valid = 1'b0;
    total++; if (out_rd_data !== 32'h7) begin bad++; $display("[TB] FAIL b2b_h0_rd got=%h exp=7", out_rd_data); end
    total++; if (out_wen !== 1'b0) begin bad++; $display("[TB] FAIL b2b_h0_wen got=%b exp=0", out_wen); end
    total++; if (d1_rd !== 32'h7) begin bad++; $display("[TB] FAIL b2b_d1_h0 got=%h exp=7", d1_rd); end
    total++; if (d4_rd !== 32'h7) begin bad++; $display("[TB] FAIL b2b_d4_h0 got=%h exp=7", d4_rd); end
  endtask

  // A write ages through the history; each DEPTH loses it at a different cycle.
  task automatic test_depth();
    logic [31:0] exp1 [6];
    logic [31:0] exp2 [6];
    logic [31:0] exp4 [6];
    exp1 = '{32'h5, 32'h5, 32'h0, 32'h0, 32'h0, 32'h0};
    exp2 = '{32'h5, 32'h5, 32'h5, 32'h0, 32'h0, 32'h0};
    exp4 = '{32'h5, 32'h5, 32'h5, 32'h5, 32'h5, 32'h0};
    do_reset();
    csr_rdata = 32'h0;
    drive(RW, 12'h340, 5'd1, 32'h5);
    tick();
    drive(RS, 12'h340, 5'd0, 32'h0);
    for (int k = 0; k < 6; k++) begin
      tick();
      total++; if (d1_rd !== exp1[k]) begin bad++; $display("[TB] FAIL depth1_rd[%0d] got=%h exp=%h", k, d1_rd, exp1[k]); end
      total++; if (out_rd_data !== exp2[k]) begin bad++; $display("[TB] FAIL depth2_rd[%0d] got=%h exp=%h", k, out_rd_data, exp2[k]); end
      total++; if (d4_rd !== exp4[k]) begin bad++; $display("[TB] FAIL depth4_rd[%0d] got=%h exp=%h", k, d4_rd, exp4[k]); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_no_write();
    do_reset();
    csr_rdata = 32'h1800;
    drive(RS, 12'h300, 5'd0, 32'hFF);
    tick();
    total++; if (out_wen !== 1'b0) begin bad++; $display("[TB] FAIL rs_x0_wen got=%b exp=0", out_wen); end
    total++; if (out_rd_data !== 32'h1800) begin bad++; $display("[TB] FAIL rs_x0_rd got=%h exp=1800", out_rd_data); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL rs_x0_valid got=%b exp=1", out_valid); end
    drive(RCI, 12'h300, 5'd0, 32'hFFFFFFFF);
    tick();
    total++; if (out_wen !== 1'b0) begin bad++; $display("[TB] FAIL rci0_wen got=%b exp=0", out_wen); end
    drive(RC, 12'h300, 5'd3, 32'h800);
    tick();
    total++; if (out_wen !== 1'b1) begin bad++; $display("[TB] FAIL rc_wen got=%b exp=1", out_wen); end
    total++; if (out_wdata !== 32'h1000) begin bad++; $display("[TB] FAIL rc_wdata got=%h exp=1000", out_wdata); end
    drive(RWI, 12'h340, 5'h1F, 32'hFFFFFFFF);
    tick();
    total++; if (out_wdata !== 32'h1F) begin bad++; $display("[TB] FAIL rwi_wdata got=%h exp=1f", out_wdata); end
    in_valid = 1'b1;
    inst     = 32'h00500093;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bubble_addi got=%b exp=0", out_valid); end
    drive(3'b100, 12'h340, 5'd1, 32'h1);
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bubble_f3_100 got=%b exp=0", out_valid); end
  endtask

  task automatic test_illegal();
    do_reset();
    csr_rdata = 32'h55;
    drive(RW, 12'hC00, 5'd1, 32'h1);
    tick();
    total++; if (out_illegal !== 1'b1) begin bad++; $display("[TB] FAIL ro_write_ill got=%b exp=1", out_illegal); end
    total++; if (out_wen !== 1'b0) begin bad++; $display("[TB] FAIL ro_write_wen got=%b exp=0", out_wen); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL ro_write_valid got=%b exp=1", out_valid); end
    drive(RS, 12'hC00, 5'd0, 32'h1);
    tick();
    total++; if (out_illegal !== 1'b0) begin bad++; $display("[TB] FAIL ro_read_ill got=%b exp=0", out_illegal); end
    total++; if (out_rd_data !== 32'h55) begin bad++; $display("[TB] FAIL ro_read_rd got=%h exp=55", out_rd_data); end
    priv = 2'd0;
    drive(RW, 12'h300, 5'd1, 32'h1);
    tick();
    total++; if (out_illegal !== 1'b1) begin bad++; $display("[TB] FAIL upriv_ill got=%b exp=1", out_illegal); end
    total++; if (out_wen !== 1'b0) begin bad++; $display("[TB] FAIL upriv_wen got=%b exp=0", out_wen); end
    priv = 2'd1;
    csr_rdata = 32'h22;
    drive(RS, 12'h100, 5'd0, 32'h0);
    tick();
    total++; if (out_illegal !== 1'b0) begin bad++; $display("[TB] FAIL spriv_s_ill got=%b exp=0", out_illegal); end
    total++; if (out_rd_data !== 32'h22) begin bad++; $display("[TB] FAIL spriv_s_rd got=%h exp=22", out_rd_data); end
    drive(RS, 12'h340, 5'd0, 32'h0);
    tick();
    in_valid = 1'b0;
    priv     = 2'd3;
    total++; if (out_illegal !== 1'b1) begin bad++; $display("[TB] FAIL spriv_m_ill got=%b exp=1", out_illegal); end
  endtask

  task automatic test_stall();
    do_reset();
    csr_rdata = 32'h0;
    drive(RW, 12'h341, 5'd1, 32'h33);
    tick();
    drive(RW, 12'h340, 5'd1, 32'h9);
    tick();
    out_ready = 1'b0;
    drive(RS, 12'h341, 5'd0, 32'h0);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL stall_in_ready got=%b exp=0", in_ready); end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL stall_valid[%0d] got=%b exp=1", k, out_valid); end
      total++; if (out_waddr !== 12'h340) begin bad++; $display("[TB] FAIL stall_waddr[%0d] got=%h exp=340", k, out_waddr); end
      total++; if (out_wdata !== 32'h9) begin bad++; $display("[TB] FAIL stall_wdata[%0d] got=%h exp=9", k, out_wdata); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL stall_ready[%0d] got=%b exp=0", k, in_ready); end
    end
    out_ready = 1'b1;
    tick();
    total++; if (out_rd_data !== 32'h33) begin bad++; $display("[TB] FAIL stall_hist_rd got=%h exp=33", out_rd_data); end
    drive(RS, 12'h340, 5'd0, 32'h0);
    tick();
    total++; if (out_rd_data !== 32'h9) begin bad++; $display("[TB] FAIL release_h0_rd got=%h exp=9", out_rd_data); end
    drive(RW, 12'h340, 5'd1, 32'h77);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midstall_rst_valid got=%b exp=0", out_valid); end
    total++; if (out_wdata !== 32'h0) begin bad++; $display("[TB] FAIL midstall_rst_wdata got=%h exp=0", out_wdata); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL midstall_rst_ready got=%b exp=1", in_ready); end
    out_ready = 1'b1;
    csr_rdata = 32'hABC;
    drive(RS, 12'h340, 5'd0, 32'h0);
    tick();
    in_valid = 1'b0;
    total++; if (out_rd_data !== 32'hABC) begin bad++; $display("[TB] FAIL midstall_rst_rd got=%h exp=abc", out_rd_data); end
  endtask

  task automatic test_flush();
    do_reset();
    csr_rdata = 32'h0;
    drive(RW, 12'h340, 5'd1, 32'h9);
    tick();
    flush = 1'b1;
    drive(RW, 12'h341, 5'd1, 32'h44);
    tick();
    flush = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_valid got=%b exp=0", out_valid); end
    csr_rdata = 32'h12345678;
    drive(RS, 12'h340, 5'd0, 32'h0);
    tick();
    total++; if (out_rd_data !== 32'h12345678) begin bad++; $display("[TB] FAIL flush_killed_rd got=%h exp=12345678", out_rd_data); end
    drive(RS, 12'h341, 5'd0, 32'h0);
    tick();
    total++; if (out_rd_data !== 32'h12345678) begin bad++; $display("[TB] FAIL flush_input_rd got=%h exp=12345678", out_rd_data); end
    drive(RW, 12'h342, 5'd1, 32'h1);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_stall_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL flush_stall_ready got=%b exp=1", in_ready); end
    out_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; inst = 32'h0; rs1_val = 32'h0; priv = 2'd3;
    flush = 1'b0; csr_rdata = 32'h0; out_ready = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_depth();
    test_no_write();
    test_illegal();
    test_stall();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
